// File: rtl/v_alu_div_unit_pkg.sv
// Shared vector ALU op package.
// Holds the lane op codes, the divide-unit FSM state type and the small
// decode helpers the lane decoder and the divide unit both use.
package v_alu_div_unit_pkg;

  localparam logic [4:0] add_op  = 5'b00010;
  localparam logic [4:0] divu_op = 5'b01101;
  localparam logic [4:0] divs_op = 5'b01110;
  localparam logic [4:0] remu_op = 5'b01111;
  localparam logic [4:0] rems_op = 5'b10000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  function automatic logic is_div_class(input logic [4:0] op);
    return (op == divu_op) || (op == divs_op) || (op == remu_op) || (op == rems_op);
  endfunction

  function automatic logic is_signed_div(input logic [4:0] op);
    return (op == divs_op) || (op == rems_op);
  endfunction

  // Remainder ops select the partial remainder rather than the quotient.
  function automatic logic is_rem_op(input logic [4:0] op);
    return (op == remu_op) || (op == rems_op);
  endfunction

endpackage

// File: rtl/v_alu_div_unit_step.sv
// v_div_step: one combinational restoring-division step.
// Shifts the next dividend bit into the partial remainder and subtracts the
// divisor when it fits.
// Ports:
//   rem_i  [DATA_WIDTH:0]   partial remainder in
//   bit_i                   next dividend bit (MSB first)
//   dvsr_i [DATA_WIDTH-1:0] divisor magnitude
//   rem_o  [DATA_WIDTH:0]   partial remainder out
//   q_o                     quotient bit produced by this step
module v_div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH:0]   rem_i,
  input  logic                  bit_i,
  input  logic [DATA_WIDTH-1:0] dvsr_i,
  output logic [DATA_WIDTH:0]   rem_o,
  output logic                  q_o
);

  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH+1:0] full_shifted;

  // The top remainder bit only carries weight for the compare; it is always
  // zero for a non-zero divisor, and with a zero divisor the low bits simply
  // accumulate the dividend.
  assign shifted      = {rem_i[DATA_WIDTH-1:0], bit_i};
  assign full_shifted = {rem_i, bit_i};

  always_comb begin
    q_o   = (full_shifted >= {2'b00, dvsr_i});
    rem_o = shifted;
    if (q_o) begin
      rem_o = shifted - {1'b0, dvsr_i};
    end
  end

endmodule

// File: rtl/v_alu_div_unit.sv
// v_alu_div_unit: iterative divide/remainder unit for a vector ALU lane.
// Executes divu/divs/remu/rems with restoring division, one quotient bit per
// cycle, followed by a single sign-fix cycle. Non divide-class ops complete
// immediately with err_o set and a zero result.
// Optional build macro V_DIV_EARLY_OUT_EN: divide-by-zero and signed overflow
// complete straight from the accepting edge instead of iterating.
// Ports:
//   clk, reset          core clock, synchronous active-high reset
//   valid_i / ready_o   request handshake (op_i, a_i dividend, b_i divisor)
//   valid_o / ready_i   result handshake (result_o, err_o)
module v_alu_div_unit
  import v_alu_div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [4:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  err_o
);

  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  div_state_t            state, state_nxt;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [4:0]            op_r;
  logic [DATA_WIDTH-1:0] quot;
  logic [DATA_WIDTH-1:0] dvsr;
  logic [DATA_WIDTH:0]   prem;
  logic                  q_neg, r_neg, b_zero;
  logic [DATA_WIDTH-1:0] result_r;
  logic                  err_r;

  logic                  accept;
  logic                  sgn_i;
  logic                  bz_i;
  logic [DATA_WIDTH-1:0] a_mag, b_mag;
  logic [DATA_WIDTH:0]   step_rem;
  logic                  step_q;

  // Magnitude of a two's-complement value; the most negative value maps to
  // its correct unsigned magnitude.
  function automatic logic [DATA_WIDTH-1:0] mag(input logic [DATA_WIDTH-1:0] v,
                                                input logic is_signed);
    logic signed [DATA_WIDTH-1:0] sv;
    sv = v;
    return (is_signed && (sv < 0)) ? -v : v;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] neg_if(input logic [DATA_WIDTH-1:0] v,
                                                   input logic n);
    return n ? -v : v;
  endfunction

`ifdef V_DIV_EARLY_OUT_EN
  logic ovf_i;

  // Divide by zero wins over overflow: quotient all ones, remainder = a.
  // Overflow: quotient = a, remainder = 0.
  function automatic logic [DATA_WIDTH-1:0] special_result(input logic [4:0] op,
                                                           input logic [DATA_WIDTH-1:0] a,
                                                           input logic bz);
    if (bz) return is_rem_op(op) ? a : '1;
    return is_rem_op(op) ? '0 : a;
  endfunction

  assign ovf_i = is_signed_div(op_i) && (a_i == MOST_NEG) && (b_i == '1);
`endif

  assign accept = valid_i && (state == IDLE);
  assign sgn_i  = is_signed_div(op_i);
  assign bz_i   = (b_i == '0);
  assign a_mag  = mag(a_i, sgn_i);
  assign b_mag  = mag(b_i, sgn_i);

  v_div_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .rem_i (prem),
    .bit_i (quot[DATA_WIDTH-1]),
    .dvsr_i(dvsr),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_o   = 1'b0;
    valid_o   = 1'b0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          if (!is_div_class(op_i)) begin
            state_nxt = DONE;
          end else begin
`ifdef V_DIV_EARLY_OUT_EN
            state_nxt = (bz_i || ovf_i) ? DONE : CALC;
`else
            state_nxt = CALC;
`endif
          end
        end
      end
      CALC: begin
        if (cnt == CNT_WIDTH'(1)) state_nxt = FIX;
      end
      FIX: begin
        state_nxt = DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Quotient register starts holding the dividend magnitude and shifts
  // quotient bits in from the bottom as dividend bits leave the top.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      result_r <= '0;
      err_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_r   <= op_i;
            quot   <= a_mag;
            dvsr   <= b_mag;
            prem   <= '0;
            q_neg  <= sgn_i && (a_i[DATA_WIDTH-1] ^ b_i[DATA_WIDTH-1]);
            r_neg  <= sgn_i && a_i[DATA_WIDTH-1];
            b_zero <= bz_i;
            if (!is_div_class(op_i)) begin
              result_r <= '0;
              err_r    <= 1'b1;
            end else begin
              cnt   <= CNT_WIDTH'(DATA_WIDTH);
              err_r <= 1'b0;
`ifdef V_DIV_EARLY_OUT_EN
              if (bz_i || ovf_i) result_r <= special_result(op_i, a_i, bz_i);
`endif
            end
          end
        end
        CALC: begin
          prem <= step_rem;
          quot <= {quot[DATA_WIDTH-2:0], step_q};
          cnt  <= cnt - CNT_WIDTH'(1);
        end
        FIX: begin
          // Overflow falls out of the datapath naturally; only the signed
          // divide-by-zero quotient needs forcing to all ones.
          if (is_rem_op(op_r))  result_r <= neg_if(prem[DATA_WIDTH-1:0], r_neg);
          else if (b_zero)      result_r <= '1;
          else                  result_r <= neg_if(quot, q_neg);
          err_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign result_o = result_r;
  assign err_o    = err_r;

endmodule

// File: tb/tb_v_alu_div_unit.sv
module tb_v_alu_div_unit;
  import v_alu_div_unit_pkg::*;

  localparam int DW = 32;
  localparam int NORM_LAT = DW + 2;
`ifdef V_DIV_EARLY_OUT_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = DW + 2;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_i;
  logic          ready_o;
  logic [4:0]    op_i;
  logic [DW-1:0] a_i, b_i;
  logic          valid_o;
  logic          ready_i;
  logic [DW-1:0] result_o;
  logic          err_o;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_res_q[$];
  logic          exp_err_q[$];
  int            exp_lat_q[$];

  always #5 clk = ~clk;

  v_alu_div_unit #(.DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .reset   (reset),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .result_o(result_o),
    .err_o   (err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one request, wait for the result and compare it with the scoreboard
  // entry. Latency counts edges from the accepting edge (inclusive) to the
  // edge after which valid_o is seen high. If consume is set the result is
  // taken with ready_i high at the next edge.
  task automatic run_op(input logic [4:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] exp_res, input logic exp_err, input int exp_lat,
                        input string tag, input bit consume);
    int n;
    logic [DW-1:0] er;
    logic ee;
    int el;
    chk({tag, "_ready"}, 64'(ready_o), 64'd1);
    op_i    = op;
    a_i     = a;
    b_i     = b;
    valid_i = 1'b1;
    exp_res_q.push_back(exp_res);
    exp_err_q.push_back(exp_err);
    exp_lat_q.push_back(exp_lat);
    @(posedge clk); #1;
    valid_i = 1'b0;
    n = 1;
    while (!valid_o && n < 200) begin
      if (n == 2) chk({tag, "_busy_ready"}, 64'(ready_o), 64'd0);
      @(posedge clk); #1;
      n++;
    end
    er = exp_res_q.pop_front();
    ee = exp_err_q.pop_front();
    el = exp_lat_q.pop_front();
    chk({tag, "_valid"}, 64'(valid_o), 64'd1);
    chk({tag, "_lat"}, 64'(n), 64'(el));
    chk({tag, "_res"}, 64'(result_o), 64'(er));
    chk({tag, "_err"}, 64'(err_o), 64'(ee));
    if (consume) begin
      @(posedge clk); #1;
      chk({tag, "_released"}, 64'(valid_o), 64'd0);
    end
  endtask

  initial begin
    int saw_valid;
    reset   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    op_i    = '0;
    a_i     = '0;
    b_i     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_result", 64'(result_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic unsigned and signed operations
    run_op(divu_op, 32'd100, 32'd7, 32'd14, 1'b0, NORM_LAT, "divu_100_7", 1'b1);
    run_op(remu_op, 32'd100, 32'd7, 32'd2, 1'b0, NORM_LAT, "remu_100_7", 1'b1);
    run_op(rems_op, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 1'b0, NORM_LAT, "rems_m100_7", 1'b1);
    run_op(divs_op, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0, NORM_LAT, "divs_m100_7", 1'b1);
    run_op(divs_op, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, NORM_LAT, "divs_7_m2", 1'b1);
    run_op(rems_op, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, NORM_LAT, "rems_7_m2", 1'b1);
    run_op(divs_op, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 1'b0, NORM_LAT, "divs_m7_m2", 1'b1);
    run_op(divu_op, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, NORM_LAT, "divu_max_1", 1'b1);
    run_op(divu_op, 32'd3, 32'd10, 32'd0, 1'b0, NORM_LAT, "divu_3_10", 1'b1);
    run_op(remu_op, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 1'b0, NORM_LAT, "remu_big", 1'b1);

    // Special cases: signed overflow and divide by zero
    run_op(divs_op, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, SPEC_LAT, "divs_ovf", 1'b1);
    run_op(rems_op, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, SPEC_LAT, "rems_ovf", 1'b1);
    run_op(divu_op, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, SPEC_LAT, "divu_by0", 1'b1);
    run_op(remu_op, 32'd5, 32'd0, 32'd5, 1'b0, SPEC_LAT, "remu_by0", 1'b1);
    run_op(divs_op, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1'b0, SPEC_LAT, "divs_m5_by0", 1'b1);
    run_op(rems_op, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b0, SPEC_LAT, "rems_m5_by0", 1'b1);

    // Backpressure: result held while ready_i is low, new requests ignored
    ready_i = 1'b0;
    run_op(divu_op, 32'd1000, 32'd10, 32'd100, 1'b0, NORM_LAT, "bp_divu", 1'b0);
    for (int i = 0; i < 10; i++) begin
      valid_i = i[0];
      op_i    = divu_op;
      a_i     = 32'd77 + 32'(i);
      b_i     = 32'd3;
      @(posedge clk); #1;
      chk("bp_hold_valid", 64'(valid_o), 64'd1);
      chk("bp_hold_res", 64'(result_o), 64'd100);
      chk("bp_hold_ready", 64'(ready_o), 64'd0);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 64'(valid_o), 64'd0);
    chk("bp_release_ready", 64'(ready_o), 64'd1);
    @(posedge clk); #1;
    chk("bp_idle_ready", 64'(ready_o), 64'd1);

    // Reset in the middle of an iteration discards the partial result
    op_i    = divu_op;
    a_i     = 32'd50;
    b_i     = 32'd5;
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("mid_busy", 64'(ready_o), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_ready", 64'(ready_o), 64'd1);
    chk("mid_rst_valid", 64'(valid_o), 64'd0);
    chk("mid_rst_result", 64'(result_o), 64'd0);
    saw_valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (valid_o) saw_valid++;
    end
    chk("mid_no_emit", 64'(saw_valid), 64'd0);
    run_op(divu_op, 32'd9, 32'd3, 32'd3, 1'b0, NORM_LAT, "post_rst_divu", 1'b1);

    // Non divide-class op flags an error and completes immediately
    run_op(add_op, 32'd12, 32'd34, 32'd0, 1'b1, 1, "add_err", 1'b1);
    chk("add_idle_ready", 64'(ready_o), 64'd1);
    run_op(divu_op, 32'd81, 32'd9, 32'd9, 1'b0, NORM_LAT, "after_err", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/v_alu_div_unit.md
Name: v_alu_div_unit

Overview:
- Iterative multi-cycle divide/remainder unit for the vector core ALU lane, width-parametrised.
- Executes the divu_op, divs_op, remu_op and rems_op opcodes from the shared vector ALU op package (5-bit encodings 01101/01110/01111/10000).
- Sits beside the single-cycle lane ALU and is selected when the lane decoder sees a divide-class op.
- valid/ready handshake on both sides, so the lane can stall on it.

Parameters:
- DATA_WIDTH, 32: operand and result width in bits; legal values 8..64.
- CNT_WIDTH, $clog2(DATA_WIDTH+1): iteration counter width; derived, never overridden.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- valid_i  in  1  request valid.
- ready_o  out  1  unit can accept a request.
- op_i  in  5  ALU op code.
- a_i  in  DATA_WIDTH  dividend.
- b_i  in  DATA_WIDTH  divisor.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts the result.
- result_o  out  DATA_WIDTH  quotient or remainder.
- err_o  out  1  op_i was not a divide-class op; qualified by valid_o.

Behaviour:
- Reset: state=IDLE, ready_o=1, valid_o=0, result_o=0, err_o=0, counter=0. Reset overrides any in-flight operation; a partial result is discarded, never emitted.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE: ready_o=1. On valid_i&&ready_o the unit latches op_i, a_i and b_i.
  - Divide-class op: go to CALC, counter=DATA_WIDTH.
  - Any other op: go to DONE with result_o=0, err_o=1.
- Operand prep at accept: for signed ops (divs/rems), operands convert to magnitudes. Record quotient sign = sign(a) XOR sign(b) and remainder sign = sign(a).
- CALC: restoring division, one quotient bit per cycle, MSB first. Partial remainder is DATA_WIDTH+1 bits. Counter decrements each cycle; go to FIX when it reaches 1.
- FIX (1 cycle): apply sign correction, select quotient (div ops) or remainder (rem ops) into result_o, go to DONE.
- DONE: valid_o=1 and result_o/err_o held stable until ready_i. On valid_o&&ready_i go to IDLE, valid_o=0.
- ready_o=0 in CALC, FIX and DONE. No back-to-back overlap: a new request is accepted only in IDLE.
- Latency: valid_o rises DATA_WIDTH+2 clock edges after the accepting edge. Throughput: one op per DATA_WIDTH+3 cycles when ready_i is held high.
- Divide by zero (b=0), RISC-V semantics: quotient = all ones (divu and divs); remainder = a (remu and rems).
- Signed overflow (a = most negative, b = -1): divs result = a; rems result = 0.
- Without the optional feature, both special cases still take the full DATA_WIDTH+2 latency and produce these values through the datapath or FIX override.
- valid_i while not ready_o: ignored, no state change.
- ready_i high in IDLE: no effect.

Optional Feature:
- Macro: V_DIV_EARLY_OUT_EN.
- Defined: at the accepting edge, b=0 or signed overflow sends the FSM directly to DONE with the special-case result. valid_o rises 1 edge after accept.
- Undefined: no bypass; all divide-class ops take DATA_WIDTH+2 edges. Results are identical in both builds; only latency differs.

Decomposition:
- The shared vector ALU op package keeps the op codes.
- Add to that package:
  - state enum typedef (IDLE, CALC, FIX, DONE);
  - function is_div_class(op) covering the four codes;
  - function is_signed_div(op) covering divs/rems.
- One sub-module, v_div_step: combinational single restoring step (partial remainder and divisor in; next remainder and quotient bit out), instantiated once in CALC.
- The FSM, counter and sign logic stay in the top module.

Test Plan (DATA_WIDTH=32):
- divu a=100, b=7, ready_i=1 → result_o=14, valid_o exactly 34 edges after accept, err_o=0.
- rems a=-100 (0xFFFFFF9C), b=7 → result_o=-2 (0xFFFFFFFE); divs same operands → -14 (0xFFFFFFF2).
- divs a=0x80000000, b=0xFFFFFFFF → 0x80000000; rems → 0. divu a=5, b=0 → 0xFFFFFFFF; remu → 5. Latency is 34 without V_DIV_EARLY_OUT_EN and 1 with it.
- Backpressure: hold ready_i=0 for 10 cycles after valid_o → result_o stable, ready_o=0, valid_i pulses ignored. On ready_i=1 → valid_o falls next edge and ready_o=1.
- Reset asserted mid-CALC (cycle 15) → next edge: ready_o=1, valid_o=0, no result emitted. A following divu 9/3 → 3.
- op_i=add_op (00010) → DONE next edge with err_o=1, result_o=0; returns to IDLE on ready_i.
